// File: rtl/i2c_target.sv
// i2c_target: I2C register-pointer target (addr, pointer, data with auto-increment); define I2C_STRETCH_EN for read clock stretching
module i2c_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_t,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr_strobe,
    output logic [7:0] rd_addr,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    input  logic       rd_valid,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD_FETCH, RD, RD_ACK, WAIT_STOP
    } state_t;
    localparam logic [3:0] FLT_MAX = 4'(FILTER_LEN - 1);
    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic [3:0] scl_cnt, sda_cnt;
    logic       scl_f, sda_f, scl_q, sda_q, fall_d;
    logic [7:0] sh, ptr, byte_in;
    logic [2:0] bit_cnt;
    logic       rw, scl_rise, scl_fall, start, stop, late, addr_hit, fetch_ok;
    assign scl_o    = 1'b0;
    assign sda_o    = 1'b0;
    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign start    = scl_f & scl_q & sda_q & ~sda_f;
    assign stop     = scl_f & scl_q & ~sda_q & sda_f;
    assign byte_in  = {sh[6:0], sda_f};
    assign addr_hit = (byte_in[7:1] == DEV_ADDR) && (DEV_ADDR != 7'h00);
    assign late     = ~scl_f & ~scl_fall;
`ifdef I2C_STRETCH_EN
    logic stretch;
    assign scl_t    = ~stretch;
    assign fetch_ok = rd_valid;
`else
    logic unused_rd_valid;
    assign scl_t           = 1'b1;
    assign fetch_ok        = 1'b1;
    assign unused_rd_valid = rd_valid;
`endif
    // Synchronise both pads and accept a new level only after it holds FILTER_LEN clocks
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            fall_d   <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_cnt  <= (scl_sync[1] == scl_f || scl_cnt == FLT_MAX) ? '0 : scl_cnt + 4'd1;
            sda_cnt  <= (sda_sync[1] == sda_f || sda_cnt == FLT_MAX) ? '0 : sda_cnt + 4'd1;
            if (scl_sync[1] != scl_f && scl_cnt == FLT_MAX) scl_f <= scl_sync[1];
            if (sda_sync[1] != sda_f && sda_cnt == FLT_MAX) sda_f <= sda_sync[1];
            scl_q    <= scl_f;
            sda_q    <= sda_f;
            fall_d   <= scl_fall;
        end
    end
    // Protocol FSM: START/STOP first, then bit sampling on SCL rise and SDA updates one clock after SCL fall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            sda_t     <= 1'b1;
            sh        <= '0;
            ptr       <= '0;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_strobe <= 1'b0;
            rd_addr   <= '0;
            rd_req    <= 1'b0;
            busy      <= 1'b0;
`ifdef I2C_STRETCH_EN
            stretch   <= 1'b0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            rd_req    <= 1'b0;
            if (start || stop) begin
                state   <= start ? ADDR : IDLE;
                bit_cnt <= '0;
                sda_t   <= 1'b1;
                if (stop) busy <= 1'b0;
`ifdef I2C_STRETCH_EN
                stretch <= 1'b0;
`endif
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        sh      <= byte_in;
                        if (bit_cnt == 3'd7) begin
                            state <= addr_hit ? ADDR_ACK : IDLE;
                            rw    <= sda_f;
                            busy  <= addr_hit;
                        end
                    end
                    ADDR_ACK, PTR_ACK, WR_ACK: begin
                        if (fall_d) sda_t <= 1'b0;
                        if (scl_rise) begin
                            bit_cnt <= '0;
                            if (state == ADDR_ACK && rw) begin
                                state   <= RD_FETCH;
                                rd_req  <= 1'b1;
                                rd_addr <= ptr;
                            end else begin
                                state <= (state == ADDR_ACK) ? PTR : WR;
                            end
                        end
                    end
                    PTR, WR: begin
                        if (fall_d) sda_t <= 1'b1;
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            sh      <= byte_in;
                            if (bit_cnt == 3'd7) begin
                                state <= (state == PTR) ? PTR_ACK : WR_ACK;
                                if (state == PTR) begin
                                    ptr <= byte_in;
                                end else begin
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= byte_in;
                                    ptr       <= ptr + 8'd1;
                                end
                            end
                        end
                    end
                    RD_FETCH: begin
                        if (fall_d) sda_t <= 1'b1;
                        if (!rd_req && fetch_ok) begin
                            state   <= RD;
                            bit_cnt <= '0;
                            ptr     <= ptr + 8'd1;
                            sh      <= late ? {rd_data[6:0], 1'b0} : rd_data;
                            if (late) sda_t <= rd_data[7];
                        end
`ifdef I2C_STRETCH_EN
                        else if (!rd_req && !scl_f) stretch <= 1'b1;
`endif
                    end
                    RD: begin
`ifdef I2C_STRETCH_EN
                        stretch <= 1'b0;
`endif
                        if (fall_d) begin
                            sda_t <= sh[7];
                            sh    <= {sh[6:0], 1'b0};
                        end
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= RD_ACK;
                        end
                    end
                    RD_ACK: begin
                        if (fall_d) sda_t <= 1'b1;
                        if (scl_rise) begin
                            bit_cnt <= '0;
                            if (sda_f) begin
                                state <= WAIT_STOP;
                            end else begin
                                state   <= RD_FETCH;
                                rd_req  <= 1'b1;
                                rd_addr <= ptr;
                            end
                        end
                    end
                    default: sda_t <= 1'b1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bit-level I2C controller bench for i2c_target
`timescale 1ns/1ps
module tb_i2c_target;
    localparam int Q = 5;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic scl_o, scl_t, sda_o, sda_t;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic wr_strobe, rd_req, busy;
    logic rd_valid = 1'b0;
    wire scl_line = scl_m & (scl_t | scl_o);
    wire sda_line = sda_m & (sda_t | sda_o);
    logic [15:0] wr_log[$];
    logic [7:0]  rd_log[$];
    logic [7:0]  rd_mem[256];
    int rd_delay = 0;
    int errors = 0;
    int checks = 0;
    int stretch_clks = 0;

    i2c_target dut (
        .clk(clk), .resetn(resetn),
        .scl_i(scl_line), .scl_o(scl_o), .scl_t(scl_t),
        .sda_i(sda_line), .sda_o(sda_o), .sda_t(sda_t),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
        .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time exhausted, required finish");
        $fatal(1);
    end

    initial forever begin
        @(negedge clk);
        if (wr_strobe) wr_log.push_back({wr_addr, wr_data});
        if (rd_req) rd_log.push_back(rd_addr);
    end

    initial forever begin
        @(negedge clk);
        if (rd_req) begin
            repeat (rd_delay) @(negedge clk);
            rd_data  = rd_mem[rd_addr];
            rd_valid = 1'b1;
            repeat (2) @(negedge clk);
            rd_valid = 1'b0;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        int n = 0;
        scl_m = 1'b0;
        wait_clk(Q);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        while (scl_line !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        stretch_clks = n;
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL scl_release: SCL held low %0d clks, required release", n);
        end
        wait_clk(Q);
        r = sda_line;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
        xfer_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic r;
        logic [7:0] v = '0;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, r);
            v[i] = r;
        end
        xfer_bit(ack, r);
        d = v;
    endtask

    task automatic bus_start;
        sda_m = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic bus_rstart;
        scl_m = 1'b0;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(2 * Q);
        sda_m = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic bus_stop;
        scl_m = 1'b0;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(2 * Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        wait_clk(3);
        checks++; if (scl_t !== 1'b1) begin errors++; $display("FAIL reset_scl_t: got %b required 1", scl_t); end
        checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL reset_sda_t: got %b required 1", sda_t); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe: got %b required 0", wr_strobe); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b required 0", rd_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if ({scl_o, sda_o} !== 2'b00) begin errors++; $display("FAIL reset_pad_o: got %b required 00", {scl_o, sda_o}); end
        resetn = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_write;
        logic a0, a1, a2, a3;
        wr_log.delete();
        bus_start;
        send_byte(8'hA0, a0);
        send_byte(8'h10, a1);
        send_byte(8'hAA, a2);
        send_byte(8'hBB, a3);
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL write_acks: got %b required 0000", {a0, a1, a2, a3}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b required 1", busy); end
        bus_stop;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop: got %b required 0", busy); end
        checks++;
        if (wr_log.size() != 2 || wr_log[0] !== 16'h10AA || wr_log[1] !== 16'h11BB) begin
            errors++;
            $display("FAIL write_strobes: got n=%0d %h %h required n=2 10aa 11bb", wr_log.size(), wr_log[0], wr_log[1]);
        end
    endtask

    task automatic test_read;
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        rd_log.delete();
        rd_mem[8'h20] = 8'h5A;
        rd_mem[8'h21] = 8'hC3;
        bus_start;
        send_byte(8'hA0, a0);
        send_byte(8'h20, a1);
        bus_rstart;
        send_byte(8'hA1, a2);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL read_acks: got %b required 000", {a0, a1, a2}); end
        recv_byte(1'b0, d0);
        recv_byte(1'b1, d1);
        checks++; if (d0 !== 8'h5A) begin errors++; $display("FAIL read_byte0: got %h required 5a", d0); end
        checks++; if (d1 !== 8'hC3) begin errors++; $display("FAIL read_byte1: got %h required c3", d1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy_nack: got %b required 1", busy); end
        bus_stop;
        checks++;
        if (rd_log.size() != 2 || rd_log[0] !== 8'h20 || rd_log[1] !== 8'h21) begin
            errors++;
            $display("FAIL read_req_addrs: got n=%0d %h %h required n=2 20 21", rd_log.size(), rd_log[0], rd_log[1]);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_stop: got %b required 0", busy); end
    endtask

    task automatic test_addr_nack;
        logic a0, a1, a2, a3;
        wr_log.delete();
        rd_log.delete();
        bus_start;
        send_byte(8'hA2, a0);
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL nack_addr_ack: got %b required 1", a0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy: got %b required 0", busy); end
        bus_stop;
        checks++; if (wr_log.size() + rd_log.size() != 0) begin errors++; $display("FAIL nack_strobes: got %0d required 0", wr_log.size() + rd_log.size()); end
        bus_start;
        send_byte(8'hA0, a1);
        send_byte(8'h30, a2);
        send_byte(8'h77, a3);
        bus_stop;
        checks++; if ({a1, a2, a3} !== 3'b000) begin errors++; $display("FAIL nack_retry_acks: got %b required 000", {a1, a2, a3}); end
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== 16'h3077) begin
            errors++;
            $display("FAIL nack_retry_strobe: got n=%0d %h required n=1 3077", wr_log.size(), wr_log[0]);
        end
    endtask

    task automatic test_wrap;
        logic a0, a1, a2, a3;
        wr_log.delete();
        bus_start;
        send_byte(8'hA0, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h01, a2);
        send_byte(8'h02, a3);
        bus_stop;
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wrap_acks: got %b required 0000", {a0, a1, a2, a3}); end
        checks++;
        if (wr_log.size() != 2 || wr_log[0] !== 16'hFF01 || wr_log[1] !== 16'h0002) begin
            errors++;
            $display("FAIL wrap_strobes: got n=%0d %h %h required n=2 ff01 0002", wr_log.size(), wr_log[0], wr_log[1]);
        end
    endtask

    task automatic test_glitch;
        logic a0, a1, a2, a3, r;
        wr_log.delete();
        @(negedge clk) sda_m = 1'b0;
        @(negedge clk) sda_m = 1'b1;
        wait_clk(2 * Q);
        send_byte(8'hA0, a0);
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL glitch_no_start_ack: got %b required 1", a0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_no_start_busy: got %b required 0", busy); end
        bus_start;
        send_byte(8'hA0, a1);
        send_byte(8'h40, a2);
        xfer_bit(1'b0, r);
        @(negedge clk) sda_m = 1'b1;
        @(negedge clk) sda_m = 1'b0;
        for (int i = 0; i < 7; i++) xfer_bit(1'b0, r);
        xfer_bit(1'b1, a3);
        checks++; if ({a1, a2, a3} !== 3'b000) begin errors++; $display("FAIL glitch_acks: got %b required 000", {a1, a2, a3}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b required 1", busy); end
        bus_stop;
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== 16'h4000) begin
            errors++;
            $display("FAIL glitch_strobe: got n=%0d %h required n=1 4000", wr_log.size(), wr_log[0]);
        end
    endtask

    task automatic test_reset_mid;
        logic a0, a1, a2, a3, a4, r;
        rd_mem[8'h08] = 8'h00;
        bus_start;
        send_byte(8'hA0, a0);
        send_byte(8'h08, a1);
        bus_rstart;
        send_byte(8'hA1, a2);
        for (int i = 0; i < 3; i++) xfer_bit(1'b1, r);
        checks++; if ({a0, a1, a2, sda_t} !== 4'b0000) begin errors++; $display("FAIL rstmid_pre: acks+sda_t got %b required 0000", {a0, a1, a2, sda_t}); end
        scl_m = 1'b0;
        wait_clk(2);
        resetn = 1'b0;
        #1;
        checks++; if ({scl_t, sda_t} !== 2'b11) begin errors++; $display("FAIL rstmid_release: scl_t,sda_t got %b required 11", {scl_t, sda_t}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        wait_clk(3);
        resetn = 1'b1;
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(2 * Q);
        send_byte(8'hA0, a3);
        checks++; if (a3 !== 1'b1) begin errors++; $display("FAIL rstmid_idle_ack: got %b required 1", a3); end
        bus_start;
        send_byte(8'hA0, a4);
        checks++; if (a4 !== 1'b0) begin errors++; $display("FAIL rstmid_restart_ack: got %b required 0", a4); end
        bus_stop;
    endtask

`ifdef I2C_STRETCH_EN
    task automatic test_stretch;
        logic a0, a1, a2, r;
        logic [7:0] v = '0;
        int s;
        rd_mem[8'h60] = 8'h96;
        rd_delay = 200;
        bus_start;
        send_byte(8'hA0, a0);
        send_byte(8'h60, a1);
        bus_rstart;
        send_byte(8'hA1, a2);
        xfer_bit(1'b1, r);
        s = stretch_clks;
        v[7] = r;
        for (int i = 6; i >= 0; i--) begin
            xfer_bit(1'b1, r);
            v[i] = r;
        end
        xfer_bit(1'b1, r);
        bus_stop;
        rd_delay = 0;
        checks++; if (s <= 150) begin errors++; $display("FAIL stretch_len: got %0d clks required >150", s); end
        checks++; if (v !== 8'h96) begin errors++; $display("FAIL stretch_byte: got %h required 96", v); end
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL stretch_acks: got %b required 000", {a0, a1, a2}); end
    endtask
`endif

    initial begin
        test_reset;
        test_write;
        test_read;
        test_addr_nack;
        test_wrap;
        test_glitch;
        test_reset_mid;
`ifdef I2C_STRETCH_EN
        test_stretch;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
